// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble control for the five-stage Y86-64 pipeline.
// It resolves the hazards forwarding cannot cover (load/use, mispredicted jumps,
// ret in flight, exceptions) and runs a run-state FSM with the states
// FLUSH -> RUN -> HALT/FAULT.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating hazard counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc_en,
  output logic [1:0]       cpu_stat
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] STAT_HLT  = 4'd2;
  localparam logic [3:0] STAT_ADR  = 4'd3;
  localparam logic [3:0] STAT_INS  = 4'd4;

  // Flush counter counts FLUSH_CYCLES-1 down to 0 so FLUSH lasts FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_flush_cnt;
  logic [3:0] w_flush_cnt_nxt;

  logic w_lu;
  logic w_mp;
  logic w_rt;
  logic w_mx;
  logic w_wx;

  // Hazard terms, purely combinational from the stage registers.
  always_comb begin
    w_lu = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) &&
           (E_dstM != REG_NONE) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    w_mp = (E_icode == IC_JXX) && !e_Cnd;
    w_rt = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
    w_mx = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS);
    w_wx = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
  end

  // Run-state register and flush down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= FLUSH_INIT;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state logic: leave FLUSH when the counter is spent, freeze on W exceptions.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (W_stat == STAT_HLT) begin
          w_state_nxt = ST_HALT;
        end else if (w_wx) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_FLUSH;
    endcase
  end

  // Pipeline register controls; reset forces the FLUSH pattern immediately.
  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    W_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    set_cc_en = 1'b0;
    if (rst || (r_state == ST_FLUSH)) begin
      F_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (r_state == ST_RUN) begin
      F_stall   = w_lu | w_rt;
      D_stall   = w_lu;
      // A stalled D register must not also be bubbled: the stall wins.
      D_bubble  = (w_mp | (w_rt & !w_lu)) & !w_lu;
      E_bubble  = w_mp | w_lu;
      M_bubble  = w_mx | w_wx;
      W_stall   = w_wx;
      set_cc_en = !(w_mx | w_wx) && (E_icode != IC_HALT) && (E_icode != IC_NOP);
    end else begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end
  end

  assign cpu_stat = r_state;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic             w_ret_evt;

  assign w_ret_evt = D_bubble & w_rt & !w_mp;

  // Saturating hazard counters, counting only while the pipe is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
      r_ret_cnt     <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_lu && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_mp && (r_mispred_cnt != CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end else begin
        r_mispred_cnt <= r_mispred_cnt;
      end
      if (w_ret_evt && (r_ret_cnt != CNT_MAX)) begin
        r_ret_cnt <= r_ret_cnt + CNT_ONE;
      end else begin
        r_ret_cnt <= r_ret_cnt;
      end
    end else begin
      r_stall_cnt   <= r_stall_cnt;
      r_mispred_cnt <= r_mispred_cnt;
      r_ret_cnt     <= r_ret_cnt;
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign mispred_cnt = r_mispred_cnt;
  assign ret_cnt     = r_ret_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Expected control vectors are
// queued as each cycle's stimulus is applied and compared mid-cycle.
// Vector layout: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, cpu_stat[1:0]}.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 32;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] D_icode, E_icode, M_icode;
  logic [3:0] d_srcA, d_srcB, E_dstM;
  logic       e_Cnd;
  logic [3:0] m_stat, W_stat;
  logic       F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc_en;
  logic [1:0] cpu_stat;
`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, mispred_cnt, ret_cnt;
`endif

  int total_cnt;
  int bad_cnt;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  // Control patterns (without cpu_stat)
  localparam logic [6:0] V_FLUSH  = 7'b1011100;
  localparam logic [6:0] V_FROZEN = 7'b1101110;
  localparam logic [6:0] V_IDLE   = 7'b0000000;
  localparam logic [6:0] V_LU     = 7'b1101001;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .D_icode    (D_icode),
    .E_icode    (E_icode),
    .M_icode    (M_icode),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .E_dstM     (E_dstM),
    .e_Cnd      (e_Cnd),
    .m_stat     (m_stat),
    .W_stat     (W_stat),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .W_stall    (W_stall),
    .D_bubble   (D_bubble),
    .E_bubble   (E_bubble),
    .M_bubble   (M_bubble),
    .set_cc_en  (set_cc_en),
    .cpu_stat   (cpu_stat)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .mispred_cnt(mispred_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: total=%0d bad=%0d, simulation did not finish", total_cnt, bad_cnt);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF;
    e_Cnd   = 1'b0;
    m_stat  = 4'd1; W_stat  = 4'd1;
  endtask

  task automatic set_lu();
    set_idle();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
  endtask

  // Queue the expectation for the stimulus already applied, then compare mid-cycle
  task automatic cyc(input string tag, input logic [6:0] ctl, input logic [1:0] st);
    logic [8:0] obs;
    exp_q.push_back({ctl, st});
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, cpu_stat};
    check_val(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int s, input int m, input int r);
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, "_stall"},   32'(stall_cnt),   32'(s));
    check_val({tag, "_mispred"}, 32'(mispred_cnt), 32'(m));
    check_val({tag, "_ret"},     32'(ret_cnt),     32'(r));
`endif
  endtask

  task automatic flush3(input string tag);
    for (int i = 0; i < 3; i++) cyc(tag, V_FLUSH, 2'd0);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held two cycles, then three FLUSH cycles, then RUN
    cyc("rst_a", V_FLUSH, 2'd0);
    cyc("rst_b", V_FLUSH, 2'd0);
    chk_cnt("rst_cnt", 0, 0, 0);
    rst = 1'b0;
    flush3("flush");
    cyc("run_idle", V_IDLE, 2'd1);

    // Load/use
    set_lu();
    cyc("loaduse", V_LU, 2'd1);
    set_idle();
    cyc("lu_after", V_IDLE, 2'd1);
    chk_cnt("lu_cnt", 1, 0, 0);

    // Mispredict, then the same jump taken
    E_icode = 4'h7; e_Cnd = 1'b0;
    cyc("mispred", 7'b0011001, 2'd1);
    e_Cnd = 1'b1;
    cyc("jmp_taken", 7'b0000001, 2'd1);
    chk_cnt("mp_cnt", 1, 1, 0);

    // ret moving through D, E, M
    set_idle(); D_icode = 4'h9;
    cyc("ret_d", 7'b1010000, 2'd1);
    set_idle(); E_icode = 4'h9;
    cyc("ret_e", 7'b1010001, 2'd1);
    set_idle(); M_icode = 4'h9;
    cyc("ret_m", 7'b1010000, 2'd1);
    // ret in D combined with load/use: stall beats bubble
    set_idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    cyc("ret_lu", V_LU, 2'd1);
    set_idle();
    cyc("ret_after", V_IDLE, 2'd1);
    chk_cnt("ret_cnt", 2, 1, 3);

    // Memory-stage address fault, then write-back fault -> FAULT
    m_stat = 4'd3;
    cyc("mx", 7'b0000100, 2'd1);
    m_stat = 4'd1; W_stat = 4'd3;
    cyc("wx_fault", 7'b0000110, 2'd1);
    set_idle();
    cyc("fault_a", V_FROZEN, 2'd3);
    set_lu();
    cyc("fault_b", V_FROZEN, 2'd3);
    chk_cnt("fault_cnt", 2, 1, 3);

    // Reset out of FAULT
    set_idle(); rst = 1'b1;
    cyc("rst_fault", V_FLUSH, 2'd3);
    rst = 1'b0;
    flush3("flush2");
    chk_cnt("cnt_clr", 0, 0, 0);
    cyc("run2", V_IDLE, 2'd1);

    // Write-back halt -> HALT
    W_stat = 4'd2;
    cyc("wx_halt", 7'b0000110, 2'd1);
    set_idle();
    cyc("halt_a", V_FROZEN, 2'd2);
    cyc("halt_b", V_FROZEN, 2'd2);

    // Reset in HALT, then reset again in the middle of FLUSH
    rst = 1'b1;
    cyc("rst_halt", V_FLUSH, 2'd2);
    rst = 1'b0;
    cyc("flush_part", V_FLUSH, 2'd0);
    rst = 1'b1;
    cyc("rst_midflush", V_FLUSH, 2'd0);
    rst = 1'b0;
    flush3("flush3");
    cyc("run3", V_IDLE, 2'd1);

    // Long load/use run: counter saturates when it is narrow
    set_lu();
    for (int i = 0; i < 20; i++) cyc("sat_lu", V_LU, 2'd1);
`ifdef HAZARD_PERF_CNT_EN
    check_val("sat_val", 32'(stall_cnt), 32'hF);
`endif
    cyc("sat_lu_more", V_LU, 2'd1);
`ifdef HAZARD_PERF_CNT_EN
    check_val("sat_hold", 32'(stall_cnt), 32'hF);
`endif
    set_idle();
    cyc("end_idle", V_IDLE, 2'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
